// File: rtl/cam_cfg_seq_pkg.sv
// ---------------------------------------------------------------------------
// cam_cfg_pkg
// Shared types and constants for the camera register-configuration sequencer.
//
// Contents:
//   cfg_state_e      - sequencer FSM states
//   CFG_END_MARK     - table word that terminates a pass
//   CFG_DELAY_TAG    - top byte that marks a delay command
//   CFG_DELAY_SHIFT  - left shift applied to a delay command's 16-bit count
//   CFG_TMR_W        - width of the shared wait/settle/watchdog counter
//   cfg_is_delay()   - true when a table word is a delay command
//   cfg_delay_cycles - wait length encoded in a delay command
// ---------------------------------------------------------------------------
package cam_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETTLE,
        FETCH,
        DECODE,
        WAIT_DONE,
        WAIT_CLR,
        DELAY,
        FINISH,
        ERROR
    } cfg_state_e;

    localparam logic [23:0] CFG_END_MARK    = 24'hFFFFFF;
    localparam logic [7:0]  CFG_DELAY_TAG   = 8'hFE;
    localparam int          CFG_DELAY_SHIFT = 10;

    // A 16-bit delay count shifted by 10 needs 26 bits.
    localparam int          CFG_TMR_W       = 26;

    function automatic logic cfg_is_delay(input logic [23:0] word);
        return word[23:16] == CFG_DELAY_TAG;
    endfunction

    function automatic logic [CFG_TMR_W-1:0] cfg_delay_cycles(input logic [23:0] word);
        return CFG_TMR_W'(word[15:0]) << CFG_DELAY_SHIFT;
    endfunction

endpackage

// File: rtl/cam_cfg_seq_if.sv
// ---------------------------------------------------------------------------
// cam_cfg_seq_if
// Bus bundle between the configuration sequencer, its command table and the
// SCCB/I2C write engine.
//
// Signals:
//   rom_addr  [ADDR_W] table read address           (master -> slave)
//   rom_data  [24]     table word, 1 cycle after addr (slave -> master)
//   send_dat  [24]     word presented to the engine  (master -> slave)
//   sendit             level request to the engine   (master -> slave)
//   done               engine transfer complete      (slave -> master)
//   ack                slave acknowledged, valid while done=1 (slave -> master)
//
// Modports: master = sequencer side, slave = table + engine side.
// ---------------------------------------------------------------------------
interface cam_cfg_seq_if #(
    parameter int ADDR_W = 6
);

    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data;
    logic [23:0]       send_dat;
    logic              sendit;
    logic              done;
    logic              ack;

    modport master (
        output rom_addr,
        output send_dat,
        output sendit,
        input  rom_data,
        input  done,
        input  ack
    );

    modport slave (
        input  rom_addr,
        input  send_dat,
        input  sendit,
        output rom_data,
        output done,
        output ack
    );

endinterface

// File: rtl/cfg_wait_timer.sv
// ---------------------------------------------------------------------------
// cfg_wait_timer
// Loadable down-counter with a zero flag. One instance is shared by the
// power-up settle wait, table delay commands and the optional watchdog,
// which never run at the same time.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous reset, active-high (count -> 0)
//   load      in   load load_val this cycle (wins over dec)
//   load_val  in   CFG_TMR_W  value to load
//   dec       in   decrement by one; holds at zero
//   zero      out  count is zero
// ---------------------------------------------------------------------------
module cfg_wait_timer
    import cam_cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CFG_TMR_W-1:0] load_val,
    input  logic                 dec,
    output logic                 zero
);

    logic [CFG_TMR_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CFG_TMR_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cam_cfg_seq.sv
// ---------------------------------------------------------------------------
// cam_cfg_seq
// Camera register-configuration sequencer. After a start pulse and a sensor
// power-up settle time, walks a 24-bit command table
// {slave_addr, reg_addr, data}, issuing each register write through the
// SCCB/I2C engine's level handshake, honouring delay commands (top byte FE)
// and retrying NACKed writes up to RETRY_MAX times. 24'hFFFFFF ends a pass;
// the walk also stops after NUM_REGS entries.
//
// Ports:
//   meg25      in   25 MHz system clock
//   rst        in   synchronous reset, active-high
//   start      in   single-cycle pulse, begins a pass (ignored unless idle)
//   bus        master modport of cam_cfg_seq_if (table + engine handshake)
//   busy       out  pass in progress
//   cfg_done   out  pass completed, sticky until next start/rst
//   cfg_err    out  pass aborted, sticky until next start/rst
//   err_index  out  ADDR_W  table index of the entry that failed
//
// Build option: define CFG_TIMEOUT_EN to add a watchdog on the engine
// handshake. A WAIT_DONE timeout counts as a NACK; a WAIT_CLR timeout aborts
// the pass. Without it the handshake waits indefinitely.
// ---------------------------------------------------------------------------
module cam_cfg_seq
    import cam_cfg_pkg::*;
#(
    parameter int NUM_REGS       = 64,
    parameter int ADDR_W         = 6,
    parameter int SETTLE_CYCLES  = 25000,
    parameter int RETRY_MAX      = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              meg25,
    input  logic              rst,
    input  logic              start,
    cam_cfg_seq_if.master     bus,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] err_index
);

    // One extra bit so the index can reach NUM_REGS when the table is full.
    localparam int IDX_W = ADDR_W + 1;
    localparam int RTY_W = $clog2(RETRY_MAX + 2);

    localparam logic [IDX_W-1:0]     IDX_LIM   = IDX_W'(NUM_REGS);
    localparam logic [RTY_W-1:0]     RETRY_LIM = RTY_W'(RETRY_MAX);
    // The timer runs load_val+1 cycles before its zero flag is seen.
    localparam logic [CFG_TMR_W-1:0] SETTLE_LD =
        CFG_TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
`ifdef CFG_TIMEOUT_EN
    localparam logic [CFG_TMR_W-1:0] TMO_LD =
        CFG_TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`else
    localparam logic [CFG_TMR_W-1:0] TMO_LD = '0;
`endif

    if (2 ** ADDR_W < NUM_REGS) begin : g_bad_addr_w
        $error("cam_cfg_seq: ADDR_W too narrow for NUM_REGS");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 2 ** CFG_TMR_W)) begin : g_bad_timeout
        $error("cam_cfg_seq: TIMEOUT_CYCLES out of range");
    end

    cfg_state_e         state_q;
    logic [IDX_W-1:0]   index_q;
    logic [RTY_W-1:0]   retry_q;
    logic               ack_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [23:0]        send_dat_q;
    logic               sendit_q;
    logic               busy_q;
    logic               cfg_done_q;
    logic               cfg_err_q;
    logic [ADDR_W-1:0]  err_index_q;

    logic [IDX_W-1:0]     idx_nxt;
    logic                 tmr_load;
    logic                 tmr_dec;
    logic [CFG_TMR_W-1:0] tmr_val;
    logic                 tmr_zero;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_LIM) ? idx : idx + IDX_W'(1);
    endfunction

    assign idx_nxt = idx_inc(index_q);

    // Timer commands follow the FSM transitions: load on entry to a timed
    // state, count down while in it.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                tmr_load = start;
                tmr_val  = SETTLE_LD;
            end
            SETTLE, DELAY: begin
                tmr_dec = 1'b1;
            end
            DECODE: begin
                tmr_load = 1'b1;
                tmr_val  = cfg_is_delay(bus.rom_data) ? cfg_delay_cycles(bus.rom_data) : TMO_LD;
            end
`ifdef CFG_TIMEOUT_EN
            WAIT_DONE: begin
                if (bus.done || tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            WAIT_CLR: begin
                if (!bus.done) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    cfg_wait_timer u_timer (
        .clk      (meg25),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge meg25) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            retry_q     <= '0;
            ack_q       <= 1'b0;
            rom_addr_q  <= '0;
            send_dat_q  <= '0;
            sendit_q    <= 1'b0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_index_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cfg_done_q <= 1'b0;
                        cfg_err_q  <= 1'b0;
                        retry_q    <= '0;
                        index_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr_zero) begin
                        rom_addr_q <= index_q[ADDR_W-1:0];
                        state_q    <= FETCH;
                    end
                end
                // rom_addr was set on entry; the word is valid next cycle.
                FETCH: begin
                    state_q <= DECODE;
                end
                DECODE: begin
                    if ((bus.rom_data == CFG_END_MARK) || (index_q == IDX_LIM)) begin
                        state_q <= FINISH;
                    end else if (cfg_is_delay(bus.rom_data)) begin
                        state_q <= DELAY;
                    end else if (!bus.done) begin
                        // Hold here if the engine still shows done from an
                        // aborted transfer, so sendit never rises over done.
                        send_dat_q <= bus.rom_data;
                        sendit_q   <= 1'b1;
                        state_q    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.done) begin
                        ack_q    <= bus.ack;
                        sendit_q <= 1'b0;
                        state_q  <= WAIT_CLR;
                    end
`ifdef CFG_TIMEOUT_EN
                    else if (tmr_zero) begin
                        ack_q    <= 1'b0;
                        sendit_q <= 1'b0;
                        state_q  <= WAIT_CLR;
                    end
`endif
                end
                WAIT_CLR: begin
                    if (!bus.done) begin
                        if (ack_q) begin
                            index_q    <= idx_nxt;
                            rom_addr_q <= idx_nxt[ADDR_W-1:0];
                            retry_q    <= '0;
                            state_q    <= FETCH;
                        end else if (retry_q < RETRY_LIM) begin
                            // send_dat still holds the failed word.
                            retry_q  <= retry_q + RTY_W'(1);
                            sendit_q <= 1'b1;
                            state_q  <= WAIT_DONE;
                        end else begin
                            state_q <= ERROR;
                        end
                    end
`ifdef CFG_TIMEOUT_EN
                    else if (tmr_zero) begin
                        state_q <= ERROR;
                    end
`endif
                end
                DELAY: begin
                    if (tmr_zero) begin
                        index_q    <= idx_nxt;
                        rom_addr_q <= idx_nxt[ADDR_W-1:0];
                        state_q    <= FETCH;
                    end
                end
                FINISH: begin
                    cfg_done_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                ERROR: begin
                    cfg_err_q   <= 1'b1;
                    err_index_q <= index_q[ADDR_W-1:0];
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.send_dat = send_dat_q;
    assign bus.sendit   = sendit_q;
    assign busy         = busy_q;
    assign cfg_done     = cfg_done_q;
    assign cfg_err      = cfg_err_q;
    assign err_index    = err_index_q;

endmodule

// File: doc/cam_cfg_seq.md
Name: cam_cfg_seq

Overview:
- Camera register-configuration sequencer. Drives the existing SCCB/I2C write engine (`i2c`) through its level handshake (`send_dat`/`sendit` → `done`/`ack`).
- Walks an external 24-bit command table: {slave_addr[7:0], reg_addr[7:0], data[7:0]}. Inserts delays and retries NACKed writes.
- Sits between power-up/reset logic and the `i2c` instance in the camera front-end. It is the only master of that engine.

Parameters:
- NUM_REGS, 64: table depth in entries; also the hard upper bound on the walk.
- ADDR_W, 6: table address width; must satisfy 2**ADDR_W >= NUM_REGS.
- SETTLE_CYCLES, 25000: `meg25` cycles to wait after `start` before the first fetch (sensor power-up).
- RETRY_MAX, 3: retries per entry after a NACK, before declaring an error.
- TIMEOUT_CYCLES, 65535: watchdog limit; used only with CFG_TIMEOUT_EN.

Ports:
- meg25  in  1  system clock, 25 MHz
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle pulse; begins a configuration pass
- rom_addr  out  ADDR_W  table read address
- rom_data  in  24  table word; valid exactly 1 cycle after rom_addr changes
- send_dat  out  24  word presented to `i2c`
- sendit  out  1  level request to `i2c`
- done  in  1  `i2c` transfer complete (level)
- ack  in  1  `i2c` slave acknowledged; valid while done=1
- busy  out  1  pass in progress
- cfg_done  out  1  pass completed OK; sticky until next start/rst
- cfg_err  out  1  pass aborted; sticky until next start/rst
- err_index  out  ADDR_W  entry index that failed

Behaviour:
- Reset values: rom_addr=0, send_dat=0, sendit=0, busy=0, cfg_done=0, cfg_err=0, err_index=0. State=IDLE.
- Reset mid-operation: sendit drops the next cycle. The `i2c` engine completes or aborts on its own. Reset does not wait for done.
- Table decode:
  - 24'hFFFFFF = end marker.
  - Top byte 8'hFE = delay command: wait {rom_data[15:0], 10'b0} cycles.
  - Any other word = register write.
- IDLE: on start → SETTLE. Clear cfg_done, cfg_err, retry count, index; busy=1. start outside IDLE is ignored.
- SETTLE: count SETTLE_CYCLES → FETCH.
- FETCH: drive rom_addr=index; wait 1 cycle → DECODE.
- DECODE:
  - End marker, or index==NUM_REGS → FINISH.
  - Delay command → DELAY. A delay count of 0 is legal: 0 wait cycles.
  - Otherwise latch send_dat=rom_data, sendit=1 → WAIT_DONE.
- WAIT_DONE: hold sendit and send_dat stable until done=1. Sample ack in that cycle, drop sendit → WAIT_CLR.
- WAIT_CLR: wait for done=0. Then:
  - ack=1 → index+1, retry=0, FETCH.
  - ack=0 and retry<RETRY_MAX → retry+1, re-enter the send (same index).
  - ack=0 and retry==RETRY_MAX → ERROR.
- DELAY: count down → index+1, FETCH.
- FINISH: cfg_done=1, busy=0 → IDLE.
- ERROR: cfg_err=1, err_index=index, busy=0 → IDLE.
- sendit is never re-asserted while done=1 (no back-to-back without done low).
- Index increments saturate at NUM_REGS; there is no wrap-around.
- Latency:
  - start to first sendit = SETTLE_CYCLES + 3 cycles.
  - done-low to next sendit = 3 cycles for a write following a write.

Optional Feature:
- Macro: CFG_TIMEOUT_EN.
- With the macro:
  - A watchdog counts cycles in WAIT_DONE and in WAIT_CLR.
  - Reaching TIMEOUT_CYCLES is treated as a NACK: the retry rules above apply, sendit is forced low, and the FSM waits for done=0 with a fresh timeout.
  - A timeout in WAIT_CLR → ERROR directly.
- Without the macro: the FSM waits indefinitely; no watchdog logic is synthesized.

Decomposition:
- Package cam_cfg_pkg holds:
  - state enum: IDLE, SETTLE, FETCH, DECODE, WAIT_DONE, WAIT_CLR, DELAY, FINISH, ERROR.
  - constants CFG_END_MARK=24'hFFFFFF, CFG_DELAY_TAG=8'hFE, CFG_DELAY_SHIFT=10.
- One sub-module, cfg_wait_timer: a loadable 26-bit down-counter with a zero flag. It is shared by SETTLE, DELAY and the watchdog (the states are mutually exclusive).

Test Plan:
- Table {780A12, 783405, FFFFFF}, `i2c` model acks all → two sendit pulses carrying 24'h780A12 then 24'h783405; cfg_done=1, busy=0; zero writes before SETTLE_CYCLES elapses.
- Entry 1 NACKed twice then acked → send_dat=24'h783405 sent 3 times; cfg_done=1, cfg_err=0.
- Entry 1 always NACKed, RETRY_MAX=3 → 4 attempts; cfg_err=1, err_index=1, cfg_done=0.
- Table {FE0002, 780A12, FFFFFF} → first sendit exactly 2048 cycles (+decode overhead) after DECODE; a single write follows.
- rst asserted during WAIT_DONE → next cycle sendit=0, busy=0, state IDLE; a following start runs a full clean pass.
- CFG_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, done held 0 → sendit drops after 100 cycles; retried RETRY_MAX times; cfg_err=1.
